// File: rtl/csa_mp_seq_pkg.sv
// Shared constants and types for the multi-precision add sequencer.
// Slice width, FSM state encoding and index-width helper.
package csa_mp_seq_pkg;

   localparam int CSA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int idx_w(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/csa_mp_seq_if.sv
// Operand/result handshake bundle for csa_mp_seq.
// Optional in_sub wire exists only with CSA_SEQ_SUB_EN defined.
interface csa_mp_seq_if
   import csa_mp_seq_pkg::*;
#(
   parameter int WORDS = 4
);
   logic                     in_valid;
   logic                     in_ready;
   logic [CSA_W*WORDS-1:0]   in_a;
   logic [CSA_W*WORDS-1:0]   in_b;
   logic                     in_cin;
`ifdef CSA_SEQ_SUB_EN
   logic                     in_sub;
`endif
   logic                     out_valid;
   logic                     out_ready;
   logic [CSA_W*WORDS-1:0]   out_sum;
   logic                     out_cout;

   modport master (
      output in_valid, in_a, in_b, in_cin,
`ifdef CSA_SEQ_SUB_EN
      output in_sub,
`endif
      output out_ready,
      input  in_ready, out_valid, out_sum, out_cout
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin,
`ifdef CSA_SEQ_SUB_EN
      input  in_sub,
`endif
      input  out_ready,
      output in_ready, out_valid, out_sum, out_cout
   );

endinterface

// File: rtl/g_csa32.sv
// 32-bit carry-select adder: low half ripples, high half is
// precomputed for both carries and selected by the low carry-out.
module g_csa32
   import csa_mp_seq_pkg::*;
(
   input  logic [CSA_W-1:0] a,
   input  logic [CSA_W-1:0] b,
   input  logic             cin,
   output logic [CSA_W-1:0] sum,
   output logic             cout
);
   localparam int H = CSA_W / 2;

   logic [H:0] lo;
   logic [H:0] hi0;
   logic [H:0] hi1;

   assign lo  = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]} + {{H{1'b0}}, cin};
   assign hi0 = {1'b0, a[CSA_W-1:H]} + {1'b0, b[CSA_W-1:H]};
   assign hi1 = {1'b0, a[CSA_W-1:H]} + {1'b0, b[CSA_W-1:H]} + {{H{1'b0}}, 1'b1};

   assign sum  = {(lo[H] ? hi1[H-1:0] : hi0[H-1:0]), lo[H-1:0]};
   assign cout = lo[H] ? hi1[H] : hi0[H];

endmodule

// File: rtl/csa_mp_seq.sv
// Multi-precision add sequencer: one shared g_csa32, one slice per clock.
// Define CSA_SEQ_SUB_EN to add the in_sub (A-B) mode.
module csa_mp_seq
   import csa_mp_seq_pkg::*;
#(
   parameter int WORDS = 4
)(
   input  logic         clk,
   input  logic         rst_n,
   csa_mp_seq_if.slave  bus,
   output logic         busy
);
   localparam int W     = CSA_W;
   localparam int IDX_W = idx_w(WORDS);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic               carry;
   logic [W*WORDS-1:0] a_q;
   logic [W*WORDS-1:0] b_q;
   logic [W*WORDS-1:0] sum_q;
   logic               cout_q;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               busy_q;
   logic               sub_q;

   logic [W-1:0] sl_a;
   logic [W-1:0] sl_b;
   logic [W-1:0] sl_s;
   logic         sl_co;

   assign sl_a = a_q[idx*W +: W];
   assign sl_b = sub_q ? ~b_q[idx*W +: W] : b_q[idx*W +: W];

   g_csa32 u_add (
      .a    (sl_a),
      .b    (sl_b),
      .cin  (carry),
      .sum  (sl_s),
      .cout (sl_co)
   );

   // Sequencer FSM: latch operands, walk slices LSW first, hold result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         idx         <= '0;
         carry       <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         sub_q       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  a_q        <= bus.in_a;
                  b_q        <= bus.in_b;
                  idx        <= '0;
`ifdef CSA_SEQ_SUB_EN
                  sub_q      <= bus.in_sub;
                  carry      <= bus.in_sub ? 1'b1 : bus.in_cin;
`else
                  sub_q      <= 1'b0;
                  carry      <= bus.in_cin;
`endif
                  state      <= ST_RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            ST_RUN: begin
               sum_q[idx*W +: W] <= sl_s;
               carry             <= sl_co;
               idx               <= idx + 1'b1;
               if (idx == LAST) begin
                  cout_q      <= sl_co;
                  out_valid_q <= 1'b1;
                  state       <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               state       <= ST_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = sum_q;
   assign bus.out_cout  = cout_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_csa_mp_seq.sv
// Self-checking bench for csa_mp_seq (WORDS=4): directed cases plus
// random operands checked against a wide-integer arithmetic model.
module tb_csa_mp_seq;
   localparam int WORDS = 4;
   localparam int NB    = 32 * WORDS;

   logic clk;
   logic rst_n;
   logic busy;

   int n_chk;
   int n_fail;

   csa_mp_seq_if #(.WORDS(WORDS)) bus ();

   csa_mp_seq #(.WORDS(WORDS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [NB-1:0] got,
                        input logic [NB-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [NB-1:0] rnd_wide();
      logic [NB-1:0] v;
      v = '0;
      for (int i = 0; i < WORDS; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic drive_idle();
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_cin    = 1'b0;
`ifdef CSA_SEQ_SUB_EN
      bus.in_sub    = 1'b0;
`endif
      bus.out_ready = 1'b0;
   endtask

   task automatic check_idle_reset(input string tag);
      check({tag, "_sum"},   bus.out_sum, '0);
      check({tag, "_cout"},  NB'(bus.out_cout), '0);
      check({tag, "_valid"}, NB'(bus.out_valid), '0);
      check({tag, "_ready"}, NB'(bus.in_ready), NB'(1));
      check({tag, "_busy"},  NB'(busy), '0);
   endtask

   // Issue one operation and check its result, latency and hold behaviour.
   task automatic run_op(input string tag, input logic [NB-1:0] a,
                         input logic [NB-1:0] b, input logic cin,
                         input logic sub, input int hold);
      logic [NB:0]   ref_v;
      logic [NB-1:0] held;
      int t;
      int lat;
      if (sub) ref_v = {1'b0, a} + {1'b0, ~b} + (NB+1)'(1);
      else     ref_v = {1'b0, a} + {1'b0, b} + (NB+1)'(cin);
      t = 0;
      while (!bus.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_rdy_to"}, NB'(bus.in_ready), NB'(1));
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_cin   = cin;
`ifdef CSA_SEQ_SUB_EN
      bus.in_sub   = sub;
`endif
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_a     = rnd_wide();
      bus.in_b     = rnd_wide();
      bus.in_cin   = 1'($urandom);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!bus.out_valid && lat < 20);
      check({tag, "_lat"},  NB'(lat), NB'(WORDS));
      check({tag, "_sum"},  bus.out_sum, ref_v[NB-1:0]);
      check({tag, "_cout"}, NB'(bus.out_cout), NB'(ref_v[NB]));
      check({tag, "_busy"}, NB'(busy), NB'(1));
      held = bus.out_sum;
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = 1'b1;
         bus.in_a     = rnd_wide();
         bus.in_b     = rnd_wide();
         @(posedge clk);
         #1;
         check({tag, "_hold_v"},   NB'(bus.out_valid), NB'(1));
         check({tag, "_hold_s"},   bus.out_sum, held);
         check({tag, "_hold_rdy"}, NB'(bus.in_ready), '0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check({tag, "_rel_v"},   NB'(bus.out_valid), '0);
      check({tag, "_rel_rdy"}, NB'(bus.in_ready), NB'(1));
      check({tag, "_retain"},  bus.out_sum, held);
   endtask

   initial begin
      logic [NB-1:0] ones;
      logic [NB-1:0] low96;
      logic [NB-1:0] exp3;
      logic [NB-1:0] ra;
      logic [NB-1:0] rb;
      logic          rs;
      n_chk  = 0;
      n_fail = 0;
      ones   = '1;
      low96  = '0;
      low96[95:0] = '1;
      exp3   = '0;
      exp3[96] = 1'b1;
      drive_idle();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;

      run_op("t1", NB'(80231), NB'(4234950), 1'b0, 1'b0, 0);
      check("t1_val", bus.out_sum, NB'(4315181));
      run_op("t2", ones, '0, 1'b1, 1'b0, 0);
      run_op("t3", low96, NB'(1), 1'b0, 1'b0, 0);
      check("t3_val", bus.out_sum, exp3);
      run_op("t4", rnd_wide(), rnd_wide(), 1'b1, 1'b0, 5);

      // Abort mid-run with reset.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = ones;
      bus.in_b     = ones;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_idle_reset("t5_abort");
      @(negedge clk);
      rst_n = 1'b1;
      run_op("t5", NB'(130), NB'(231), 1'b0, 1'b0, 0);
      check("t5_val", bus.out_sum, NB'(361));

`ifdef CSA_SEQ_SUB_EN
      run_op("t6a", NB'(100000000), NB'(13), 1'b1, 1'b1, 0);
      check("t6a_val", bus.out_sum, NB'(99999987));
      run_op("t6b", '0, NB'(1), 1'b0, 1'b1, 1);
      check("t6b_val", bus.out_sum, ones);
`endif

      for (int k = 0; k < 24; k++) begin
         ra = rnd_wide();
         rb = rnd_wide();
         if (k % 4 == 1) ra = ones;
         if (k % 4 == 2) rb = ~ra;
`ifdef CSA_SEQ_SUB_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         run_op("rnd", ra, rb, 1'($urandom), rs, int'($urandom_range(0, 2)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
